uart_wb_host: RTL and testbench
===============================

// Module: uart_wb_host
// PURPOSE
//  Wishbone classic initiator that drives the 16550-compatible uart_top register slave (8-bit data bus).
//  After reset it programs the baud divisor, line control and FIFO control, then serves a byte stream.
//  TX bytes arrive on a valid/ready port and RX bytes leave as single-cycle pulses, by polling LSR.
//  Sits between core logic and uart_top, replacing the unconnected Wishbone side of the UART instance.
// PARAMETERS
//  DIVISOR      16'd27  baud divisor written to DLL/DLM (clk / (16*baud))
//  LCR_VALUE    8'h03   final LCR value (8N1, DLAB=0); bit 7 is forced to 0
//  FCR_VALUE    8'h07   FCR value (FIFO enable, clear RX/TX FIFOs)
//  ACK_TIMEOUT  16      max cycles stb may stay high waiting for ack (>=2)
// PORTS
//  wb_clk_i    in   1  clock
//  wb_rst_i    in   1  synchronous active-high reset
//  wb_adr_o    out  3  register address
//  wb_dat_o    out  8  write data
//  wb_dat_i    in   8  read data, sampled on the cycle wb_ack_i=1
//  wb_we_o     out  1  1=write, 0=read
//  wb_stb_o    out  1  strobe
//  wb_cyc_o    out  1  cycle; always equal to wb_stb_o
//  wb_sel_o    out  4  byte select; constant 4'b0001
//  wb_ack_i    in   1  slave acknowledge
//  tx_data     in   8  byte to send; stable while tx_valid=1
//  tx_valid    in   1  TX request; held until tx_ready
//  tx_ready    out  1  1-cycle pulse: tx_data was written to THR
//  rx_data     out  8  received byte; holds its value until the next rx_valid
//  rx_valid    out  1  1-cycle pulse: rx_data is new; no backpressure
//  init_done   out  1  high once the init sequence has completed
//  timeout_err out  1  sticky: some access hit ACK_TIMEOUT
// BEHAVIOUR
//  Reset: all outputs 0 (wb_sel_o=4'b0001); state=INIT_LCR_DLAB; timer cleared.
//  A reset mid-access drops stb/cyc on the next edge and restarts init from INIT_LCR_DLAB.
//  Bus access: adr/dat/we/stb/cyc are registered and held constant until ack.
//   On the ack cycle the access completes and stb/cyc=0 on the next edge.
//   At most one access is outstanding, and there is at least 1 idle cycle between accesses.
//   wb_ack_i is ignored while stb=0.
//  Init sequence (writes, in order), each on completion of the previous:
//   INIT_LCR_DLAB adr3 = LCR_VALUE|8'h80 -> INIT_DLL adr0 = DIVISOR[7:0]
//   -> INIT_DLM adr1 = DIVISOR[15:8] -> INIT_LCR adr3 = LCR_VALUE&8'h7F
//   -> INIT_FCR adr2 = FCR_VALUE -> INIT_IER adr1 = 8'h00 -> POLL.
//   init_done goes 1 on the edge that leaves INIT_IER; it stays 1 until reset.
//  POLL: read adr5 (LSR). When the read completes, with lsr=wb_dat_i:
//   lsr[0]=1 (DR) -> RD_RBR; RX takes priority over TX so the RX FIFO does not overrun.
//   else lsr[5]=1 (THRE) and tx_valid=1 -> WR_THR.
//   else -> POLL again.
//  RD_RBR: read adr0. On ack: rx_data<=wb_dat_i, rx_valid=1 for one cycle, then -> POLL.
//  WR_THR: write adr0 = tx_data. On ack: tx_ready=1 for one cycle, then -> POLL.
//   Only one byte is written per LSR poll, even when the FIFO has room.
//  tx_valid dropping before tx_ready is a protocol violation; the byte captured at WR_THR entry is still sent.
//  Timeout: an 8-bit cycle counter runs while stb=1.
//   Reaching ACK_TIMEOUT with no ack aborts the access: stb/cyc=0 and timeout_err<=1.
//   An aborted init write advances to the next init state; an aborted POLL/RD/WR returns to POLL.
//   An aborted WR_THR gives no tx_ready and an aborted RD_RBR gives no rx_valid.
//  Ack and timeout in the same cycle: ack wins and the access completes normally.
// TESTING
//  1 Reset, then a slave model that always acks in 1 cycle -> 6 writes in order:
//    (3,83)(0,1B)(1,00)(3,03)(2,07)(1,00); then init_done=1; then repeated reads of adr5.
//  2 LSR returns 8'h60, tx_valid=1, tx_data=8'hA5 -> one write (0,A5); tx_ready pulses on the cycle after ack.
//  3 LSR returns 8'h61 with tx_valid=1, RBR=8'h3C -> read of adr0 comes first; rx_data=3C, rx_valid 1 cycle;
//    the next poll (8'h60) then writes the TX byte.
//  4 Slave never acks the DLL write -> stb drops after 16 cycles; timeout_err=1; the DLM write follows.
//  5 Assert wb_rst_i while stb=1 during WR_THR -> stb/cyc=0 next cycle, no tx_ready;
//    after release the init sequence restarts at (3,83).
//  6 Slave ack latency of 3 cycles -> adr/dat/we stable through the ack; cyc==stb on every cycle.

Source files
------------

// File: rtl/uart_wb_host_if.sv
`default_nettype none
// ============================================================================
// Module   : uart_wb_host_if
// Brief    : 8-bit Wishbone classic bus between uart_wb_host and uart_top.
// Revision : 1.0 - initial release
// ============================================================================
interface uart_wb_host_if;
    logic [2:0] wb_adr_o;
    logic [7:0] wb_dat_o;
    logic [7:0] wb_dat_i;
    logic       wb_we_o;
    logic       wb_stb_o;
    logic       wb_cyc_o;
    logic [3:0] wb_sel_o;
    logic       wb_ack_i;

    modport master (
        output wb_adr_o, wb_dat_o, wb_we_o, wb_stb_o, wb_cyc_o, wb_sel_o,
        input  wb_dat_i, wb_ack_i
    );

    modport slave (
        input  wb_adr_o, wb_dat_o, wb_we_o, wb_stb_o, wb_cyc_o, wb_sel_o,
        output wb_dat_i, wb_ack_i
    );
endinterface
`default_nettype wire

// File: rtl/uart_wb_host.sv
`default_nettype none
// ============================================================================
// Module   : uart_wb_host
// Brief    : Wishbone initiator that initialises a 16550 UART, then moves
//            TX/RX bytes by polling LSR.
// Revision : 1.0 - initial release
// ============================================================================
module uart_wb_host #(
    parameter logic [15:0] DIVISOR     = 16'd27,
    parameter logic [7:0]  LCR_VALUE   = 8'h03,
    parameter logic [7:0]  FCR_VALUE   = 8'h07,
    parameter int          ACK_TIMEOUT = 16
) (
    input  logic                  wb_clk_i,
    input  logic                  wb_rst_i,
    uart_wb_host_if.master        wb,
    input  logic [7:0]            tx_data,
    input  logic                  tx_valid,
    output logic                  tx_ready,
    output logic [7:0]            rx_data,
    output logic                  rx_valid,
    output logic                  init_done,
    output logic                  timeout_err
);

    localparam logic [3:0] c_INIT_LCR_DLAB = 4'd0;
    localparam logic [3:0] c_INIT_DLL      = 4'd1;
    localparam logic [3:0] c_INIT_DLM      = 4'd2;
    localparam logic [3:0] c_INIT_LCR      = 4'd3;
    localparam logic [3:0] c_INIT_FCR      = 4'd4;
    localparam logic [3:0] c_INIT_IER      = 4'd5;
    localparam logic [3:0] c_POLL          = 4'd6;
    localparam logic [3:0] c_RD_RBR        = 4'd7;
    localparam logic [3:0] c_WR_THR        = 4'd8;

    localparam logic [7:0] c_TIMER_LAST    = 8'(ACK_TIMEOUT - 1);

    logic [3:0] r_state;
    logic       r_stb;
    logic [2:0] r_adr;
    logic [7:0] r_dat;
    logic       r_we;
    logic [7:0] r_timer;
    logic [7:0] r_tx_byte;
    logic       r_tx_ready;
    logic [7:0] r_rx_data;
    logic       r_rx_valid;
    logic       r_init_done;
    logic       r_timeout_err;

    logic [2:0] w_adr;
    logic [7:0] w_dat;
    logic       w_we;
    logic [3:0] w_next;
    logic       w_finish;

    // Access descriptor for the state being entered on the next launch.
    always_comb begin
        w_adr = 3'd5;
        w_dat = 8'h00;
        w_we  = 1'b0;
        case (r_state)
            c_INIT_LCR_DLAB: begin w_adr = 3'd3; w_dat = LCR_VALUE | 8'h80;  w_we = 1'b1; end
            c_INIT_DLL:      begin w_adr = 3'd0; w_dat = DIVISOR[7:0];       w_we = 1'b1; end
            c_INIT_DLM:      begin w_adr = 3'd1; w_dat = DIVISOR[15:8];      w_we = 1'b1; end
            c_INIT_LCR:      begin w_adr = 3'd3; w_dat = LCR_VALUE & 8'h7F;  w_we = 1'b1; end
            c_INIT_FCR:      begin w_adr = 3'd2; w_dat = FCR_VALUE;          w_we = 1'b1; end
            c_INIT_IER:      begin w_adr = 3'd1; w_dat = 8'h00;              w_we = 1'b1; end
            c_RD_RBR:        begin w_adr = 3'd0; end
            c_WR_THR:        begin w_adr = 3'd0; w_dat = r_tx_byte;          w_we = 1'b1; end
            default:         begin w_adr = 3'd5; end
        endcase
    end

    // Ack beats timeout; an aborted LSR poll simply polls again.
    always_comb begin
        w_finish = r_stb && (wb.wb_ack_i || (r_timer == c_TIMER_LAST));
        w_next   = c_POLL;
        if (r_state <= c_INIT_IER) begin
            w_next = r_state + 4'd1;
        end else if (r_state == c_POLL && wb.wb_ack_i) begin
            if (wb.wb_dat_i[0]) begin
                w_next = c_RD_RBR;
            end else if (wb.wb_dat_i[5] && tx_valid) begin
                w_next = c_WR_THR;
            end
        end
    end

    always_ff @(posedge wb_clk_i) begin
        if (wb_rst_i) begin
            r_state       <= c_INIT_LCR_DLAB;
            r_stb         <= 1'b0;
            r_adr         <= 3'd0;
            r_dat         <= 8'h00;
            r_we          <= 1'b0;
            r_timer       <= 8'd0;
            r_tx_byte     <= 8'h00;
            r_tx_ready    <= 1'b0;
            r_rx_data     <= 8'h00;
            r_rx_valid    <= 1'b0;
            r_init_done   <= 1'b0;
            r_timeout_err <= 1'b0;
        end else begin
            r_tx_ready <= 1'b0;
            r_rx_valid <= 1'b0;
            if (!r_stb) begin
                r_stb   <= 1'b1;
                r_adr   <= w_adr;
                r_dat   <= w_dat;
                r_we    <= w_we;
                r_timer <= 8'd0;
            end else if (w_finish) begin
                r_stb   <= 1'b0;
                r_state <= w_next;
                if (r_state == c_INIT_IER) begin
                    r_init_done <= 1'b1;
                end
                if (wb.wb_ack_i) begin
                    if (r_state == c_RD_RBR) begin
                        r_rx_data  <= wb.wb_dat_i;
                        r_rx_valid <= 1'b1;
                    end
                    if (r_state == c_WR_THR) begin
                        r_tx_ready <= 1'b1;
                    end
                end else begin
                    r_timeout_err <= 1'b1;
                end
                // The TX byte is frozen here so a misbehaving source cannot change it mid-write.
                if (w_next == c_WR_THR) begin
                    r_tx_byte <= tx_data;
                end
            end else begin
                r_timer <= r_timer + 8'd1;
            end
        end
    end

    assign wb.wb_adr_o = r_adr;
    assign wb.wb_dat_o = r_dat;
    assign wb.wb_we_o  = r_we;
    assign wb.wb_stb_o = r_stb;
    assign wb.wb_cyc_o = r_stb;
    assign wb.wb_sel_o = 4'b0001;

    assign tx_ready    = r_tx_ready;
    assign rx_data     = r_rx_data;
    assign rx_valid    = r_rx_valid;
    assign init_done   = r_init_done;
    assign timeout_err = r_timeout_err;

endmodule
`default_nettype wire

// File: tb/tb_uart_wb_host.sv
`default_nettype none
// ============================================================================
// Module   : tb_uart_wb_host
// Brief    : Randomised scoreboard bench for uart_wb_host with a UART slave model.
// Revision : 1.0 - initial release
// ============================================================================
module tb_uart_wb_host;

    localparam int c_ACK_TO = 16;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    uart_wb_host_if wb();

    logic [7:0] tx_data;
    logic       tx_valid;
    logic       tx_ready;
    logic [7:0] rx_data;
    logic       rx_valid;
    logic       init_done;
    logic       timeout_err;

    uart_wb_host dut (
        .wb_clk_i    (clk),
        .wb_rst_i    (rst),
        .wb          (wb),
        .tx_data     (tx_data),
        .tx_valid    (tx_valid),
        .tx_ready    (tx_ready),
        .rx_data     (rx_data),
        .rx_valid    (rx_valid),
        .init_done   (init_done),
        .timeout_err (timeout_err)
    );

    int n_vec = 0;
    int n_bad = 0;

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
        end
    endtask

    // Reference model: expected bus accesses {adr,we,dat} and output events.
    logic [11:0] exp_bus[$];
    logic [7:0]  exp_rx[$];
    logic [7:0]  exp_tx[$];
    int          init_left;
    int          next_kind;   // 1 = LSR poll, 2 = RBR read, 3 = THR write
    bit          exp_init_done;
    bit          exp_tmo;
    logic [7:0]  exp_rx_hold;
    logic [7:0]  pend_tx;

    int lat_max   = 1;
    int noack_pct = 0;
    bit noack_dll = 0;
    bit tx_en     = 1;

    task automatic push_access(input int kind, input logic [2:0] adr, input logic we, input logic [7:0] dat);
        exp_bus.push_back({adr, we, dat});
        next_kind = kind;
    endtask

    task automatic model_reset();
        exp_bus.delete();
        exp_rx.delete();
        exp_tx.delete();
        exp_bus.push_back({3'd3, 1'b1, 8'h83});
        exp_bus.push_back({3'd0, 1'b1, 8'h1B});
        exp_bus.push_back({3'd1, 1'b1, 8'h00});
        exp_bus.push_back({3'd3, 1'b1, 8'h03});
        exp_bus.push_back({3'd2, 1'b1, 8'h07});
        exp_bus.push_back({3'd1, 1'b1, 8'h00});
        init_left     = 6;
        next_kind     = 1;
        exp_init_done = 0;
        exp_tmo       = 0;
        exp_rx_hold   = 8'h00;
    endtask

    task automatic model_complete(input bit aborted, input logic [7:0] rdata);
        int kind;
        kind = next_kind;
        if (aborted) exp_tmo = 1;
        if (init_left > 0) begin
            init_left--;
            if (init_left == 0) begin
                exp_init_done = 1;
                push_access(1, 3'd5, 1'b0, 8'h00);
            end
        end else if (kind == 1 && !aborted && rdata[0]) begin
            push_access(2, 3'd0, 1'b0, 8'h00);
        end else if (kind == 1 && !aborted && rdata[5] && tx_valid) begin
            pend_tx = tx_data;
            push_access(3, 3'd0, 1'b1, tx_data);
        end else begin
            if (kind == 2 && !aborted) begin
                exp_rx.push_back(rdata);
                exp_rx_hold = rdata;
            end
            if (kind == 3 && !aborted) exp_tx.push_back(pend_tx);
            push_access(1, 3'd5, 1'b0, 8'h00);
        end
    endtask

    // UART register slave with random ack latency and optional ack suppression.
    initial begin
        bit         last_stb = 0;
        bit         ack_drv  = 0;
        bit         noack    = 0;
        int         cnt      = 0;
        int         lat      = 1;
        logic [7:0] drv_dat  = 8'h00;
        wb.wb_ack_i = 1'b0;
        wb.wb_dat_i = 8'h00;
        forever begin
            @(negedge clk);
            if (rst) begin
                model_reset();
                last_stb = 0; ack_drv = 0; cnt = 0;
                wb.wb_ack_i = 1'b0;
                continue;
            end
            if (last_stb && ack_drv) begin
                model_complete(1'b0, drv_dat);
            end else if (last_stb && !wb.wb_stb_o) begin
                check("abort_cycles", 32'(cnt), 32'(c_ACK_TO));
                model_complete(1'b1, 8'h00);
            end
            if (wb.wb_stb_o) begin
                if (!last_stb) begin
                    cnt = 1;
                    lat = int'($urandom_range(1, lat_max));
                    if (noack_dll && wb.wb_adr_o == 3'd0 && wb.wb_we_o) begin
                        noack     = 1;
                        noack_dll = 0;
                    end else begin
                        noack = (int'($urandom_range(0, 99)) < noack_pct);
                    end
                end else begin
                    cnt++;
                end
                ack_drv     = !noack && (cnt == lat);
                drv_dat     = 8'($urandom);
                wb.wb_ack_i = ack_drv;
            end else begin
                cnt = 0;
                ack_drv = 0;
                // Stray acks while idle must be ignored by the initiator.
                wb.wb_ack_i = ($urandom_range(0, 3) == 0);
            end
            wb.wb_dat_i = drv_dat;
            last_stb    = wb.wb_stb_o;
        end
    end

    // TX source: holds each byte until tx_ready.
    initial begin
        tx_valid = 1'b0;
        tx_data  = 8'h00;
        forever begin
            @(negedge clk);
            #2;
            if (tx_valid && tx_ready) tx_valid = 1'b0;
            if (!tx_valid && tx_en && $urandom_range(0, 2) == 0) begin
                tx_data  = 8'($urandom);
                tx_valid = 1'b1;
            end
        end
    end

    // Monitor: pops the scoreboard whenever the DUT presents something.
    initial begin
        bit          m_stb = 0;
        bit          m_ack = 0;
        logic [11:0] m_bus = '0;
        logic [11:0] cur;
        logic [11:0] e;
        int          hi = 0;
        forever begin
            @(negedge clk);
            #1;
            if (rst) begin
                check("reset_outputs",
                      32'({wb.wb_stb_o, wb.wb_cyc_o, tx_ready, rx_valid, init_done, timeout_err, rx_data}),
                      32'h0);
                m_stb = 0; m_ack = 0; hi = 0;
                continue;
            end
            check("cyc_sel", 32'({wb.wb_cyc_o, wb.wb_sel_o}), 32'({wb.wb_stb_o, 4'b0001}));
            cur = {wb.wb_adr_o, wb.wb_we_o, wb.wb_dat_o};
            if (wb.wb_stb_o) begin
                if (!m_stb) begin
                    hi = 1;
                    if (exp_bus.size() == 0) begin
                        check("unexpected_access", 32'(cur), 32'hDEAD_BEEF);
                    end else begin
                        e = exp_bus.pop_front();
                        check("bus_access", 32'({cur[11:8], cur[8] ? cur[7:0] : 8'h00}), 32'(e));
                    end
                end else begin
                    hi++;
                    if (m_ack) check("idle_gap", 32'(m_ack), 32'(0));
                    else       check("hold_stable", 32'(cur), 32'(m_bus));
                    if (hi == c_ACK_TO + 2) check("stb_bound", 32'(hi), 32'(c_ACK_TO));
                end
            end
            check("tx_ready", 32'(tx_ready), 32'(exp_tx.size() != 0));
            if (exp_tx.size() != 0) void'(exp_tx.pop_front());
            check("rx_valid", 32'(rx_valid), 32'(exp_rx.size() != 0));
            if (exp_rx.size() != 0) void'(exp_rx.pop_front());
            check("status", 32'({init_done, timeout_err, rx_data}),
                  32'({exp_init_done, exp_tmo, exp_rx_hold}));
            m_stb = wb.wb_stb_o;
            m_ack = wb.wb_ack_i;
            m_bus = cur;
        end
    end

    initial begin
        bit found;
        rst = 1'b1;
        repeat (3) @(negedge clk);
        #3 rst = 1'b0;
        repeat (400) @(negedge clk);
        #3 lat_max = 3;
        repeat (400) @(negedge clk);

        // Lost ack on the DLL write, plus occasional lost acks afterwards.
        #3 rst = 1'b1;
        repeat (2) @(negedge clk);
        #3 noack_dll = 1; noack_pct = 5; rst = 1'b0;
        repeat (600) @(negedge clk);

        // Reset in the middle of a THR write.
        #3 noack_pct = 0;
        found = 0;
        for (int i = 0; i < 3000 && !found; i++) begin
            @(negedge clk);
            found = wb.wb_stb_o && wb.wb_we_o && (wb.wb_adr_o == 3'd0) && init_done;
        end
        check("wr_thr_seen", 32'(found), 32'(1));
        #3 rst = 1'b1;
        repeat (2) @(negedge clk);
        #3 rst = 1'b0;
        repeat (300) @(negedge clk);
        #3 tx_en = 0;
        repeat (50) @(negedge clk);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
`default_nettype wire
